// File: rtl/remme_pkg.sv
// Shared definitions for the remme register sharing logic.
package remme_pkg;

  localparam int          REMME_DW    = 4;
  localparam logic [3:0]  IDLE_CODE_C = 4'hF;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set, non-excluded request at or after start.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  win,
  output logic          vld
);

  // Walk the requests from start, wrapping modulo N; the first hit wins.
  always_comb begin
    int idx;
    win = '0;
    vld = 1'b0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(start) + k) % N;
      if (!vld && req[idx] && !excl[idx]) begin
        win[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/remme_rr_sched.sv
// Round-robin scheduler sharing one remme register among NREQ requesters.
module remme_rr_sched
  import remme_pkg::*;
#(
  parameter int         NREQ      = 4,
  parameter int         IDW       = 2,
  parameter int         MAX_BURST = 4,
  parameter logic [3:0] IDLE_CODE = IDLE_CODE_C
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          lock,
  input  logic [REMME_DW*NREQ-1:0] data,
  output logic [NREQ-1:0]          gnt,
  output logic [REMME_DW-1:0]      r_out,
  output logic [IDW-1:0]           owner,
  output logic                     owner_vld,
  output logic                     busy
);

  // bcnt counts extra cycles already granted; the last allowed value ends the burst.
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [3:0]      bcnt_q, bcnt_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic            owner_vld_q, owner_vld_d;

  logic [IDW-1:0]  hold_idx;
  logic [IDW-1:0]  hold_nxt;
  logic [IDW-1:0]  pick_start;
  logic [NREQ-1:0] pick_excl;
  logic [NREQ-1:0] pick_win;
  logic            pick_vld;
  logic            keep;

  // Index of the current holder and its successor modulo NREQ.
  always_comb begin
    hold_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) hold_idx = IDW'(i);
    end
    hold_nxt = (hold_idx == IDW'(NREQ - 1)) ? '0 : hold_idx + IDW'(1);
  end

  // On release the search restarts after the holder and skips it for this edge.
  always_comb begin
    pick_start = ptr_q;
    pick_excl  = '0;
    if (state_q == S_GRANT) begin
      pick_start = hold_nxt;
      pick_excl  = gnt_q;
    end
  end

  rr_pick #(
    .N  (NREQ),
    .IW (IDW)
  ) u_pick (
    .req   (req),
    .start (pick_start),
    .excl  (pick_excl),
    .win   (pick_win),
    .vld   (pick_vld)
  );

  // Selected value goes straight to remme r; IDLE_CODE when nobody holds the grant.
  always_comb begin
    r_out = IDLE_CODE;
    if (|gnt_q) r_out = data[hold_idx*REMME_DW +: REMME_DW];
  end

  // Next-state, grant, pointer and burst counter.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    keep    = (state_q == S_GRANT) && req[hold_idx] && lock[hold_idx] &&
              (bcnt_q < BURST_LAST);
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_GRANT;
          gnt_d   = pick_win;
          bcnt_d  = '0;
        end
      end
      S_GRANT: begin
        if (keep) begin
          bcnt_d = bcnt_q + 4'd1;
        end else begin
          ptr_d  = hold_nxt;
          bcnt_d = '0;
          if (pick_vld) begin
            gnt_d = pick_win;
          end else begin
            state_d = S_IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Remember who last wrote a real (non no-op) value.
  always_comb begin
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    if ((|gnt_q) && (r_out != IDLE_CODE)) begin
      owner_d     = hold_idx;
      owner_vld_d = 1'b1;
    end
  end

  // State registers; reset clears the grant without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      ptr_q       <= '0;
      bcnt_q      <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      bcnt_q      <= bcnt_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign owner_vld = owner_vld_q;
  assign busy      = (state_q == S_GRANT);

endmodule

// File: tb/tb_remme_rr_sched.sv
// Bench for remme_rr_sched: directed vector table, corner sequences, random vs model.
module tb_remme_rr_sched;

  localparam int N  = 4;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, lock;
  logic [15:0] data;
  logic [3:0]  gnt, r_out;
  logic [1:0]  owner;
  logic        owner_vld, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  remme_rr_sched #(
    .NREQ      (N),
    .IDW       (2),
    .MAX_BURST (MB),
    .IDLE_CODE (4'hF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .lock      (lock),
    .data      (data),
    .gnt       (gnt),
    .r_out     (r_out),
    .owner     (owner),
    .owner_vld (owner_vld),
    .busy      (busy)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [15:0] data;
    logic [3:0]  gnt;
    logic [3:0]  rout;
    logic [1:0]  own;
    logic        ovld;
    logic        busy;
  } vec_t;

  vec_t vt[17];

  // Reference model: holder (-1 when idle), pointer, cycles held so far.
  int m_hold, m_ptr, m_run, m_owner;
  bit m_ovld;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    lock  = '0;
    data  = 16'hFFFF;
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic vec_t mk(logic r, logic [3:0] q, logic [3:0] l, logic [15:0] d,
                              logic [3:0] g, logic [3:0] ro, logic [1:0] o,
                              logic ov, logic b);
    vec_t v;
    v.rst = r; v.req = q; v.lock = l; v.data = d;
    v.gnt = g; v.rout = ro; v.own = o; v.ovld = ov; v.busy = b;
    return v;
  endfunction

  function automatic logic [3:0] nib(logic [15:0] d, int i);
    return d[4*i +: 4];
  endfunction

  function automatic int search(logic [3:0] r, int start, int excl);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (j != excl && r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_hold = -1; m_ptr = 0; m_run = 0; m_owner = 0; m_ovld = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] l, input logic [15:0] d);
    if (m_hold >= 0 && nib(d, m_hold) != 4'hF) begin
      m_owner = m_hold;
      m_ovld  = 1;
    end
    if (m_hold < 0) begin
      m_hold = search(r, m_ptr, -1);
      m_run  = 1;
    end else if (r[m_hold] && l[m_hold] && m_run < MB) begin
      m_run++;
    end else begin
      m_ptr  = (m_hold + 1) % N;
      m_hold = search(r, m_ptr, m_hold);
      m_run  = 1;
    end
  endtask

  initial begin
    logic [3:0] eg, er;

    // Single requester, full round, burst limit.
    vt[0]  = mk(1, 4'b0001, 4'b0000, 16'h0007, 4'b0001, 4'h7, 2'd0, 0, 1);
    vt[1]  = mk(0, 4'b0001, 4'b0000, 16'h0007, 4'b0000, 4'hF, 2'd0, 1, 0);
    vt[2]  = mk(0, 4'b0001, 4'b0000, 16'h0007, 4'b0001, 4'h7, 2'd0, 1, 1);
    vt[3]  = mk(1, 4'b1111, 4'b0000, 16'h5263, 4'b0001, 4'h3, 2'd0, 0, 1);
    vt[4]  = mk(0, 4'b1111, 4'b0000, 16'h5263, 4'b0010, 4'h6, 2'd0, 1, 1);
    vt[5]  = mk(0, 4'b1111, 4'b0000, 16'h5263, 4'b0100, 4'h2, 2'd1, 1, 1);
    vt[6]  = mk(0, 4'b1111, 4'b0000, 16'h5263, 4'b1000, 4'h5, 2'd2, 1, 1);
    vt[7]  = mk(0, 4'b1111, 4'b0000, 16'h5263, 4'b0001, 4'h3, 2'd3, 1, 1);
    vt[8]  = mk(1, 4'b0011, 4'b0001, 16'h0021, 4'b0001, 4'h1, 2'd0, 0, 1);
    vt[9]  = mk(0, 4'b0011, 4'b0001, 16'h0021, 4'b0001, 4'h1, 2'd0, 1, 1);
    vt[10] = mk(0, 4'b0011, 4'b0001, 16'h0021, 4'b0001, 4'h1, 2'd0, 1, 1);
    vt[11] = mk(0, 4'b0011, 4'b0001, 16'h0021, 4'b0001, 4'h1, 2'd0, 1, 1);
    vt[12] = mk(0, 4'b0011, 4'b0001, 16'h0021, 4'b0010, 4'h2, 2'd0, 1, 1);
    vt[13] = mk(0, 4'b0011, 4'b0001, 16'h0021, 4'b0001, 4'h1, 2'd1, 1, 1);
    vt[14] = mk(0, 4'b0000, 4'b0000, 16'h0021, 4'b0000, 4'hF, 2'd0, 1, 0);
    vt[15] = mk(0, 4'b0000, 4'b0000, 16'h0021, 4'b0000, 4'hF, 2'd0, 1, 0);
    vt[16] = mk(0, 4'b0100, 4'b0000, 16'h0800, 4'b0100, 4'h8, 2'd0, 1, 1);

    reset = 1'b0; req = '0; lock = '0; data = 16'hFFFF;
    #12;
    chk("rst_gnt", 16'(gnt), 16'h0);
    chk("rst_rout", 16'(r_out), 16'hF);
    chk("rst_owner", 16'(owner), 16'h0);
    chk("rst_ovld", 16'(owner_vld), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      if (vt[i].rst) do_reset();
      req = vt[i].req; lock = vt[i].lock; data = vt[i].data;
      step();
      chk($sformatf("vec%0d_gnt", i), 16'(gnt), 16'(vt[i].gnt));
      chk($sformatf("vec%0d_rout", i), 16'(r_out), 16'(vt[i].rout));
      chk($sformatf("vec%0d_owner", i), 16'(owner), 16'(vt[i].own));
      chk($sformatf("vec%0d_ovld", i), 16'(owner_vld), 16'(vt[i].ovld));
      chk($sformatf("vec%0d_busy", i), 16'(busy), 16'(vt[i].busy));
    end

    // IDLE_CODE passthrough: requester 1 writes A, requester 2 presents F.
    do_reset();
    req = 4'b0110; lock = 4'b0000; data = 16'h0FA0;
    step();
    chk("pass_gnt1", 16'(gnt), 16'h2);
    chk("pass_rout1", 16'(r_out), 16'hA);
    step();
    chk("pass_gnt2", 16'(gnt), 16'h4);
    chk("pass_rout2", 16'(r_out), 16'hF);
    chk("pass_owner2", 16'(owner), 16'h1);
    step();
    chk("pass_gnt3", 16'(gnt), 16'h2);
    chk("pass_owner3", 16'(owner), 16'h1);
    chk("pass_ovld3", 16'(owner_vld), 16'h1);

    // Early drop of a locked requester with nobody else waiting.
    do_reset();
    req = 4'b1000; lock = 4'b1000; data = 16'h9000;
    step();
    chk("drop_gnt1", 16'(gnt), 16'h8);
    step();
    chk("drop_gnt2", 16'(gnt), 16'h8);
    req = 4'b0000;
    step();
    chk("drop_gnt3", 16'(gnt), 16'h0);
    chk("drop_rout3", 16'(r_out), 16'hF);
    chk("drop_busy3", 16'(busy), 16'h0);
    req = 4'b1001; lock = 4'b0000; data = 16'h9004;
    step();
    chk("drop_regnt", 16'(gnt), 16'h1);
    chk("drop_rerout", 16'(r_out), 16'h4);

    // Asynchronous reset in the middle of a locked burst.
    do_reset();
    req = 4'b0010; lock = 4'b0010; data = 16'h0050;
    step();
    step();
    chk("arst_pre_gnt", 16'(gnt), 16'h2);
    chk("arst_pre_ovld", 16'(owner_vld), 16'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_gnt", 16'(gnt), 16'h0);
    chk("arst_rout", 16'(r_out), 16'hF);
    chk("arst_ovld", 16'(owner_vld), 16'h0);
    chk("arst_busy", 16'(busy), 16'h0);
    @(negedge clk);
    reset = 1'b1;
    req = 4'b0100; lock = 4'b0000; data = 16'h0300;
    step();
    chk("arst_after_gnt", 16'(gnt), 16'h4);

    // Random stimulus against the model, with occasional async resets.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        model_reset();
      end
      req  = 4'($urandom_range(0, 15));
      lock = 4'($urandom_range(0, 15));
      for (int k = 0; k < N; k++) begin
        data[4*k +: 4] = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      end
      step();
      model_step(req, lock, data);
      eg = (m_hold < 0) ? 4'b0000 : 4'(1 << m_hold);
      er = (m_hold < 0) ? 4'hF : nib(data, m_hold);
      chk("rnd_gnt", 16'(gnt), 16'(eg));
      chk("rnd_rout", 16'(r_out), 16'(er));
      chk("rnd_owner", 16'(owner), 16'(m_owner));
      chk("rnd_ovld", 16'(owner_vld), 16'(m_ovld));
      chk("rnd_busy", 16'(busy), 16'(m_hold >= 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
